// File: rtl/hk_const_mem.sv
// ============================================================================
//  Module      : hk_const_mem
//  Description : SHA H/K constant store. Copies the H sets and K constants
//                byte-serially from an external ROM into WORD_BYTES byte-lane
//                RAM banks, then serves one word per cycle via a registered
//                read port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hk_const_mem #(
  parameter int WORD_BYTES = 4,
  parameter int K_DEPTH    = 64,
  parameter int H_SETS     = 2,
  localparam int TOTAL_BYTES = (H_SETS * 8 + K_DEPTH) * WORD_BYTES,
  localparam int AW          = $clog2(TOTAL_BYTES),
  localparam int KW          = $clog2(K_DEPTH),
  localparam int SW          = (H_SETS > 1) ? $clog2(H_SETS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    copy_rom,
  output logic                    rom_rd,
  output logic [AW-1:0]           rom_addr,
  input  logic [7:0]              rom_data,
  input  logic                    hk_selector,
  input  logic [SW-1:0]           h_set,
  input  logic [2:0]              h_addr,
  input  logic [KW-1:0]           k_addr,
  output logic [8*WORD_BYTES-1:0] hk,
  output logic                    hk_valid,
  output logic                    rdy
);

  localparam int NWORDS = H_SETS * 8 + K_DEPTH;
  localparam int WAW    = $clog2(NWORDS);
  localparam int BW     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_COPY  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic [1:0]              state;
  logic [1:0]              state_nxt;
  logic                    copy_q;
  logic                    start;
  logic                    launch;
  logic [BW-1:0]           byte_cnt;
  logic [WAW-1:0]          word_cnt;
  logic                    wr_pend;
  logic [BW-1:0]           wr_byte;
  logic [WAW-1:0]          wr_word;
  logic                    last_wr;
  logic                    rd_oor;
  logic [WAW-1:0]          rd_word;
  logic [8*WORD_BYTES-1:0] rd_data;

  // A start only counts outside COPY; a re-copy from READY is allowed.
  assign start   = copy_rom & ~copy_q;
  assign launch  = start & (state != ST_COPY);
  assign last_wr = wr_pend && (wr_word == WAW'(NWORDS - 1))
                           && (wr_byte == BW'(WORD_BYTES - 1));

  // Registered copy of the copy request for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) copy_q <= 1'b0;
    else        copy_q <= copy_rom;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (start)   state_nxt = ST_COPY;
      ST_COPY:  if (last_wr) state_nxt = ST_READY;
      ST_READY: if (start)   state_nxt = ST_COPY;
      default:               state_nxt = ST_EMPTY;
    endcase
  end

  // FSM outputs: RAM contents are valid only in READY
  always_comb begin
    rdy = (state == ST_READY);
  end

  // ROM address generator with parallel word/byte counters (no division)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_rd   <= 1'b0;
      rom_addr <= '0;
      byte_cnt <= '0;
      word_cnt <= '0;
    end else if (launch) begin
      rom_rd   <= 1'b1;
      rom_addr <= '0;
      byte_cnt <= '0;
      word_cnt <= '0;
    end else if (rom_rd) begin
      if (rom_addr == AW'(TOTAL_BYTES - 1)) begin
        rom_rd <= 1'b0;
      end else begin
        rom_addr <= rom_addr + AW'(1);
        if (byte_cnt == BW'(WORD_BYTES - 1)) begin
          byte_cnt <= '0;
          word_cnt <= word_cnt + WAW'(1);
        end else begin
          byte_cnt <= byte_cnt + BW'(1);
        end
      end
    end
  end

  // ROM data lags the address by one cycle, so the write target is delayed to match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend <= 1'b0;
      wr_byte <= '0;
      wr_word <= '0;
    end else begin
      wr_pend <= rom_rd;
      wr_byte <= byte_cnt;
      wr_word <= word_cnt;
    end
  end

  // One RAM bank per byte lane; bank 0 holds the most significant byte
  for (genvar b = 0; b < WORD_BYTES; b++) begin : g_bank
    logic [7:0] mem [NWORDS];

    // Bank write: only the lane addressed by the delayed byte index
    always_ff @(posedge clk) begin
      if (wr_pend && (wr_byte == BW'(b))) mem[wr_word] <= rom_data;
    end

    assign rd_data[8*(WORD_BYTES-1-b) +: 8] = mem[rd_word];
  end

  // Read word address and range check; H_SET is ignored for K reads
  always_comb begin
    rd_oor  = 1'b0;
    rd_word = '0;
    if (hk_selector) begin
      rd_oor  = (32'(k_addr) >= K_DEPTH);
      rd_word = WAW'(H_SETS * 8 + 32'(k_addr));
    end else begin
      rd_oor  = (32'(h_set) >= H_SETS);
      rd_word = WAW'(32'(h_set) * 8 + 32'(h_addr));
    end
  end

  // Registered read port: zero unless ready and in range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hk       <= '0;
      hk_valid <= 1'b0;
    end else begin
      hk_valid <= rdy;
      if (rdy && !rd_oor) hk <= rd_data;
      else                hk <= '0;
    end
  end

endmodule

`default_nettype wire
